// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder/subtractor).
// Holds the controller state encodings and the counter-width helpers.
// No logic of its own; imported by every serial arithmetic top.
package serial_arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) == 0.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Bit counter width: a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - b_in, with borrow out.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic b_in,
  output logic d,
  output logic b_out
);

  // Difference bit and borrow generated by this bit position.
  always_comb begin
    d     = x ^ y ^ b_in;
    b_out = (~x & y) | (~(x ^ y) & b_in);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b (mod 2^WIDTH), b_out = a < b.
// Latency: start accepted at edge E0, done pulses in the cycle after edge E0+WIDTH.
// Backpressure: start is ignored while busy; results are held until the next done.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             d_bit;
  logic             br_next;

  // The single arithmetic cell always works on the current LSBs.
  full_subtractor u_fs (
    .x     (a_sh_q[0]),
    .y     (b_sh_q[0]),
    .b_in  (br_q),
    .d     (d_bit),
    .b_out (br_next)
  );

  // Next-state logic: capture on accepted start, one bit per RUN cycle, publish on last bit.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        busy_d = 1'b0;
        if (state_q == ST_DONE) begin
          state_d = ST_IDLE;
        end
        if (start) begin
          state_d = ST_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end
      ST_RUN: begin
        a_sh_d            = a_sh_q >> 1;
        b_sh_d            = b_sh_q >> 1;
        res_d             = res_q >> 1;
        res_d[WIDTH-1]    = d_bit;
        br_d              = br_next;
        cnt_d             = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          // The last bit lands directly in the output register via res_d.
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          diff_d  = res_d;
          bout_d  = br_next;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign diff  = diff_q;
  assign b_out = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 and WIDTH=1.
// Latency: expects done exactly WIDTH+1 cycles after start is driven.
// Backpressure: exercises start during RUN and start held through DONE.
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .a     (a8),
    .b     (b8),
    .busy  (busy8),
    .done  (done8),
    .diff  (diff8),
    .b_out (bout8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .a     (a1),
    .b     (b1),
    .busy  (busy1),
    .done  (done1),
    .diff  (diff1),
    .b_out (bout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain unsigned arithmetic.
  function automatic logic [7:0] ref_diff8(input logic [7:0] x, input logic [7:0] y);
    int r;
    r = (int'(x) - int'(y) + 256) % 256;
    return r[7:0];
  endfunction

  // Full WIDTH=8 operation from start to done, checking busy window and result.
  task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] prev;
    bit         win_ok;
    prev   = diff8;
    a8     = x;
    b8     = y;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    a8     = $urandom;
    b8     = $urandom;
    win_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!(busy8 === 1'b1 && done8 === 1'b0 && diff8 === prev)) win_ok = 1'b0;
      step();
    end
    chk({tag, "_busy_window"}, 32'(win_ok), 32'd1);
    chk({tag, "_done"}, {done8, busy8}, 32'b10);
    chk({tag, "_diff"}, diff8, ref_diff8(x, y));
    chk({tag, "_bout"}, bout8, 32'(x < y));
  endtask

  task automatic op1(input string tag, input logic [0:0] x, input logic [0:0] y);
    a1     = x;
    b1     = y;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk({tag, "_busy"}, {done1, busy1}, 32'b01);
    step();
    chk({tag, "_done"}, {done1, busy1}, 32'b10);
    chk({tag, "_diff"}, diff1, 32'((int'(x) - int'(y) + 2) % 2));
    chk({tag, "_bout"}, bout1, 32'(x < y));
  endtask

  initial begin
    logic [7:0] rx, ry;
    logic [0:0] sx, sy;
    rst_n  = 1'b0;
    start8 = 1'b0;
    a8     = '0;
    b8     = '0;
    start1 = 1'b0;
    a1     = '0;
    b1     = '0;
    #2;
    chk("reset8_outputs", {busy8, done8, diff8, bout8}, 32'd0);
    chk("reset1_outputs", {busy1, done1, diff1, bout1}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle8_outputs", {busy8, done8, diff8, bout8}, 32'd0);

    // Basic subtraction and borrow corners.
    op8("t1_5a_23", 8'h5A, 8'h23);
    step();
    chk("t1_done_pulse", {done8, busy8}, 32'b00);
    chk("t1_diff_held", diff8, 32'h37);
    op8("t2_00_01", 8'h00, 8'h01);
    step();
    op8("t2_ff_ff", 8'hFF, 8'hFF);
    step();

    // start re-pulsed mid-RUN must be ignored.
    a8     = 8'h80;
    b8     = 8'h01;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    a8     = 8'h11;
    b8     = 8'h22;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    step();
    chk("t3_done", {done8, busy8}, 32'b10);
    chk("t3_diff", diff8, 32'h7F);
    chk("t3_bout", bout8, 32'd0);
    step();
    chk("t3_idle", {done8, busy8}, 32'b00);

    // start held through DONE: immediate re-entry into RUN.
    op8("t4_first", 8'h30, 8'h10);
    a8     = 8'h10;
    b8     = 8'h20;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("t4_run_busy", {done8, busy8}, 32'b01);
      chk("t4_diff_held", diff8, 32'h20);
      step();
    end
    chk("t4_done", {done8, busy8}, 32'b10);
    chk("t4_diff", diff8, 32'hF0);
    chk("t4_bout", bout8, 32'd1);
    step();

    // Reset in the middle of RUN aborts without a done pulse.
    a8     = 8'h55;
    b8     = 8'h11;
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    step();
    step();
    step();
    chk("t5_running", busy8, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_abort_outputs", {busy8, done8, diff8, bout8}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t5_no_done", {done8, busy8}, 32'b00);
    end
    rst_n = 1'b1;
    step();
    op8("t5_09_04", 8'h09, 8'h04);
    step();

    // Random WIDTH=8 sweep.
    for (int n = 0; n < 200; n++) begin
      rx = $urandom;
      ry = $urandom;
      op8("rand8", rx, ry);
      if ($urandom_range(0, 1) == 1) step();
    end
    step();

    // WIDTH=1 directed case and sweep.
    op1("t6_0_1", 1'b0, 1'b1);
    step();
    for (int n = 0; n < 1000; n++) begin
      sx = 1'($urandom_range(0, 1));
      sy = 1'($urandom_range(0, 1));
      op1("rand1", sx, sy);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
